// File: rtl/qspi_xip_pkg.sv
// Shared constants, FSM encoding and transmit-nibble helper for the QSPI XiP line fetcher.
package qspi_xip_pkg;

    localparam logic [7:0] OPC_QIO_READ = 8'hEB;
    localparam logic [7:0] MODE_CONT    = 8'hA5;
    localparam logic [7:0] MODE_EXIT    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_MODE  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_DATA  = 3'd5,
        ST_CSH   = 3'd6
    } fetch_state_e;

    // Nibble to present on IO[3:0] for SCK cycle idx of a transmit phase
    function automatic logic [3:0] tx_nibble(input fetch_state_e st, input logic [2:0] idx,
                                             input logic [23:0] a, input logic [7:0] mode);
        logic [3:0] nib;
        nib = 4'h0;
        case (st)
            ST_CMD:  nib = {3'b000, OPC_QIO_READ[3'd7 - idx]};
            ST_ADDR: begin
                case (idx)
                    3'd0:    nib = a[23:20];
                    3'd1:    nib = a[19:16];
                    3'd2:    nib = a[15:12];
                    3'd3:    nib = a[11:8];
                    3'd4:    nib = a[7:4];
                    3'd5:    nib = a[3:0];
                    default: nib = 4'h0;
                endcase
            end
            ST_MODE: nib = idx[0] ? mode[3:0] : mode[7:4];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/qspi_xip_line_fetcher_if.sv
// Cache-side request/response and flash pad signals of the line fetcher.
interface qspi_xip_line_fetcher_if #(
    parameter int LINE_BYTES = 16
);
    logic [23:0]             addr;
    logic                    rd;
    logic                    busy;
    logic                    done;
    logic [LINE_BYTES*8-1:0] line;
    logic                    sck;
    logic                    ce_n;
    logic [3:0]              din;
    logic [3:0]              dout;
    logic                    douten;

    // Cache controller plus pad ring
    modport master (
        output addr, rd, din,
        input  busy, done, line, sck, ce_n, dout, douten
    );

    // Line fetcher
    modport slave (
        input  addr, rd, din,
        output busy, done, line, sck, ce_n, dout, douten
    );
endinterface

// File: rtl/qspi_sck_gen.sv
// SCK divider: toggles sck every CLK_DIV clk while enabled, flags the clk edge of each SCK edge.
module qspi_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

    logic [2:0] div_cnt_r;
    logic       sck_r;
    logic       tick_s;

    assign tick_s = en && (div_cnt_r == DIV_LAST);
    assign rise   = tick_s && !sck_r;
    assign fall   = tick_s && sck_r;
    assign sck    = sck_r;

    // Half-period counter, parked at phase zero with sck low while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= 3'd0;
            sck_r     <= 1'b0;
        end else if (!en) begin
            div_cnt_r <= 3'd0;
            sck_r     <= 1'b0;
        end else if (tick_s) begin
            div_cnt_r <= 3'd0;
            sck_r     <= ~sck_r;
        end else begin
            div_cnt_r <= div_cnt_r + 3'd1;
        end
    end
endmodule

// File: rtl/qspi_xip_line_fetcher.sv
// Quad I/O (0xEB) flash line fetcher with continuous-read mode for the XiP cache.
module qspi_xip_line_fetcher
    import qspi_xip_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int DUMMY_CLKS = 4,
    parameter int CLK_DIV    = 1,
    parameter int CONT_READ  = 1,
    parameter int CSH_CLKS   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    qspi_xip_line_fetcher_if.slave bus
);
    localparam int          LINE_W    = LINE_BYTES * 8;
    localparam logic [7:0]  MODE_BYTE = (CONT_READ != 0) ? MODE_CONT : MODE_EXIT;
    localparam logic [23:0] LOW_MASK  = 24'(LINE_BYTES - 1);
    localparam logic [7:0]  DUMMY_LEN = 8'(DUMMY_CLKS);
    localparam logic [7:0]  DATA_LEN  = 8'(2 * LINE_BYTES);
    localparam logic [3:0]  CSH_LAST  = 4'(CSH_CLKS - 1);

    fetch_state_e      state_r;
    logic [23:0]       addr_r;
    logic              cont_r;
    logic              ce_n_r;
    logic              busy_r;
    logic              done_r;
    logic              douten_r;
    logic [3:0]        dout_r;
    logic [3:0]        hi_nib_r;
    logic [3:0]        csh_cnt_r;
    logic [7:0]        cnt_r;
    logic [LINE_W-1:0] rx_r;
    logic [LINE_W-1:0] line_r;
    logic              sck_s;
    logic              rise_s;
    logic              fall_s;

    function automatic logic [7:0] phase_len(input fetch_state_e st);
        logic [7:0] len;
        case (st)
            ST_CMD:   len = 8'd8;
            ST_ADDR:  len = 8'd6;
            ST_MODE:  len = 8'd2;
            ST_DUMMY: len = DUMMY_LEN;
            default:  len = DATA_LEN;
        endcase
        return len;
    endfunction

    qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~ce_n_r),
        .sck   (sck_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.line   = line_r;
    assign bus.sck    = sck_s;
    assign bus.ce_n   = ce_n_r;
    assign bus.dout   = dout_r;
    assign bus.douten = douten_r;

    // Fetch FSM: phases advance on the SCK fall after their last rise; data sampled on rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            addr_r    <= 24'h000000;
            cont_r    <= 1'b0;
            ce_n_r    <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            douten_r  <= 1'b0;
            dout_r    <= 4'h0;
            hi_nib_r  <= 4'h0;
            csh_cnt_r <= 4'd0;
            cnt_r     <= 8'd0;
            rx_r      <= '0;
            line_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.rd) begin
                        addr_r  <= bus.addr & ~LOW_MASK;
                        busy_r  <= 1'b1;
                        state_r <= cont_r ? ST_ADDR : ST_CMD;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA: begin
                    if (ce_n_r) begin
                        // First clk after accept: select the flash with the first nibble already out
                        ce_n_r   <= 1'b0;
                        cnt_r    <= 8'd0;
                        douten_r <= 1'b1;
                        dout_r   <= tx_nibble(state_r, 3'd0, addr_r, MODE_BYTE);
                    end else if (rise_s) begin
                        cnt_r <= cnt_r + 8'd1;
                        if (state_r == ST_DATA) begin
                            if (cnt_r[0]) begin
                                rx_r <= {hi_nib_r, bus.din, rx_r[LINE_W-1:8]};
                            end else begin
                                hi_nib_r <= bus.din;
                            end
                        end else begin
                            hi_nib_r <= hi_nib_r;
                        end
                    end else if (fall_s) begin
                        if (cnt_r == phase_len(state_r)) begin
                            cnt_r <= 8'd0;
                            case (state_r)
                                ST_CMD: begin
                                    state_r <= ST_ADDR;
                                    dout_r  <= tx_nibble(ST_ADDR, 3'd0, addr_r, MODE_BYTE);
                                end
                                ST_ADDR: begin
                                    state_r <= ST_MODE;
                                    dout_r  <= tx_nibble(ST_MODE, 3'd0, addr_r, MODE_BYTE);
                                end
                                ST_MODE: begin
                                    state_r  <= (DUMMY_CLKS != 0) ? ST_DUMMY : ST_DATA;
                                    douten_r <= 1'b0;
                                    dout_r   <= 4'h0;
                                end
                                ST_DUMMY: begin
                                    state_r <= ST_DATA;
                                end
                                default: begin
                                    state_r   <= ST_CSH;
                                    ce_n_r    <= 1'b1;
                                    done_r    <= 1'b1;
                                    line_r    <= rx_r;
                                    cont_r    <= (CONT_READ != 0);
                                    csh_cnt_r <= 4'd0;
                                end
                            endcase
                        end else begin
                            dout_r <= tx_nibble(state_r, cnt_r[2:0], addr_r, MODE_BYTE);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_CSH: begin
                    if (csh_cnt_r == CSH_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        csh_cnt_r <= csh_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ce_n_r  <= 1'b1;
                end
            endcase
        end
    end
endmodule
